serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
- Bit-serial, MSB-first magnitude comparator with a start/busy/done handshake.
- Sequential counterpart to the gate-level parallel greater-than circuits.
- Reports all three relations (a_gt_b, a_lt_b, a_eq_b) for WIDTH-bit unsigned operands, one bit examined per clock.
- Used where area matters more than latency. Its results serve as the golden cross-check for the combinational comparators.

Parameters:
WIDTH, 8, operand width in bits (minimum 2)
CNT_W, $clog2(WIDTH), bit-index counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a comparison; sampled only when busy=0
a  input  WIDTH  operand A, unsigned, captured on accepted start
b  input  WIDTH  operand B, unsigned, captured on accepted start
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse, result valid
a_gt_b  output  1  A > B, held until next accepted start
a_lt_b  output  1  A < B, held until next accepted start
a_eq_b  output  1  A == B, held until next accepted start

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - busy, done, a_gt_b, a_lt_b and a_eq_b all 0.
  - Shift registers, counter and decided flag cleared.
  - An in-flight comparison is abandoned with no done pulse.
- FSM states are IDLE, SHIFT and DONE. All outputs are registered.
- IDLE:
  - busy=0.
  - start=1 at edge k:
    - load sa<=a, sb<=b, cnt<=WIDTH-1, decided<=0;
    - clear a_gt_b, a_lt_b and a_eq_b to 0;
    - busy<=1, go to SHIFT.
- SHIFT: on each edge, examine sa[WIDTH-1] and sb[WIDTH-1].
  - If decided=0 and the bits differ: a_gt_b<=sa[MSB], a_lt_b<=sb[MSB], decided<=1.
  - Shift sa and sb left by one, zero fill.
  - Decrement cnt.
  - When cnt==0 is processed:
    - if no difference was ever found, a_eq_b<=1;
    - done<=1, busy<=0, go to DONE.
- Latency without early exit: exactly WIDTH cycles from start edge k to the done edge k+WIDTH, for every operand pair.
- DONE:
  - Lasts one cycle; done=1, busy=0.
  - Next edge: done<=0.
  - If start=1 in this cycle, it is accepted exactly as in IDLE, giving back-to-back operation. Otherwise go to IDLE.
- Results are one-hot after done. The all-zero pattern means no valid result (after reset or while busy).
- start while busy=1 is ignored. a and b are don't-care outside the accepting edge.
- Operands are unsigned. No sign handling; WIDTH bits compared exactly.

Optional Feature:
Macro SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, the first differing bit sets a_gt_b/a_lt_b, done<=1, busy<=0 and goes to DONE on that same edge.
  - A difference at bit i gives latency WIDTH-i cycles.
  - Equal operands still take WIDTH cycles.
- Undefined:
  - Fixed WIDTH-cycle latency regardless of data (constant-time behaviour).
  - The decided flag is kept to freeze the first result.

Test Plan:
- WIDTH=8, reset_n pulsed low mid-cycle (asynchronous) -> all outputs 0 immediately; no done follows.
- a=8'hA5, b=8'h5A, start one cycle -> done 8 cycles after start edge (1 cycle with EARLY_EXIT_EN); a_gt_b=1, a_lt_b=0, a_eq_b=0; result held after done.
- a=8'h10, b=8'h11 -> a_lt_b=1 after 8 cycles (8 cycles also with EARLY_EXIT_EN, difference at bit 0).
- a=b=8'h3C, and separately a=b=8'h00 and a=b=8'hFF -> a_eq_b=1 only, 8 cycles both builds.
- Start a=8'h01, b=8'h80. Pulse start with a=8'hFF, b=8'h00 at cycle 3 while busy=1 -> ignored; result a_lt_b=1. New start asserted during the done cycle with a=8'h80, b=8'h7F -> accepted; done 8 cycles later with a_gt_b=1.
- Assert reset_n=0 at cycle 4 of an operation, release, then start a=8'h02, b=8'h02 -> clean a_eq_b=1 with no residue from the aborted run.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: bit-serial, MSB-first unsigned magnitude
// comparator with a start/busy/done handshake. One operand bit pair is
// examined per clock. All outputs are registered.
//
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN
//   undefined (default): fixed WIDTH-cycle latency regardless of data.
//   defined            : finish on the first differing bit, so a difference
//                        at bit i takes WIDTH-i cycles. Equal operands still
//                        take WIDTH cycles.
module serial_magnitude_comparator #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic             diff;

  assign diff = sa_q[WIDTH-1] ^ sb_q[WIDTH-1];

  // Next-state and datapath: load on accepted start, shift/compare in SHIFT.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    case (state_q)
      // DONE accepts a start exactly like IDLE, giving back-to-back operation.
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          sa_d      = a;
          sb_d      = b;
          cnt_d     = CNT_W'(WIDTH-1);
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          eq_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = {sa_q[WIDTH-2:0], 1'b0};
        sb_d  = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        // The decided flag freezes the first (most significant) difference.
        if (!decided_q && diff) begin
          gt_d      = sa_q[WIDTH-1];
          lt_d      = sb_q[WIDTH-1];
          decided_d = 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
`endif
        end
        if (cnt_q == '0) begin
          // Last bit: equality only if no bit, including this one, differed.
          if (!decided_q && !diff) eq_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any comparison in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=8). Expected results
// and latencies are queued when a start is driven and popped on done.
module tb_serial_magnitude_comparator;
  localparam int W = 8;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, a_gt_b, a_lt_b, a_eq_b;

  int   total = 0, bad = 0;
  int   cyc = 0;
  int   k_acc = 0;
  exp_t q[$];
  exp_t last_e;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W-1; i >= 0; i--)
      if (x[i] != y[i]) return W - i;
`endif
    return W;
  endfunction

  // Drive one accepted start, queue the expectation, check busy/cleared results.
  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi);
    exp_t e;
    e.gt  = (ai > bi);
    e.lt  = (ai < bi);
    e.eq  = (ai == bi);
    e.lat = exp_lat(ai, bi);
    q.push_back(e);
    @(negedge clk);
    start = 1'b1; a = ai; b = bi;
    @(posedge clk); #1;
    k_acc = cyc;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    chk("busy_after_start", {31'b0, busy}, 1);
    chk("res_cleared", {29'b0, a_gt_b, a_lt_b, a_eq_b}, 0);
  endtask

  // Wait (bounded) for done, pop the expectation, check result and latency.
  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    bit   got = 0;
    while (n < 4*W) begin
      if (done === 1'b1) begin got = 1; break; end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, {31'b0, got}, 1);
    if (q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
      return;
    end
    e = q.pop_front();
    last_e = e;
    if (!got) return;
    chk({tag, "_latency"}, cyc - k_acc, e.lat);
    chk({tag, "_result"}, {29'b0, a_gt_b, a_lt_b, a_eq_b}, {29'b0, e.gt, e.lt, e.eq});
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 0);
  endtask

  // One cycle after done: pulse gone, result still held.
  task automatic check_held(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'b0, done}, 0);
    chk({tag, "_held"}, {29'b0, a_gt_b, a_lt_b, a_eq_b}, {29'b0, last_e.gt, last_e.lt, last_e.eq});
  endtask

  initial begin
    int seen;
    #12;
    chk("reset_outputs", {27'b0, busy, done, a_gt_b, a_lt_b, a_eq_b}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    launch(8'hA5, 8'h5A); wait_done("gt_a5_5a"); check_held("gt_a5_5a");
    launch(8'h10, 8'h11); wait_done("lt_10_11"); check_held("lt_10_11");
    launch(8'h3C, 8'h3C); wait_done("eq_3c");    check_held("eq_3c");
    launch(8'h00, 8'h00); wait_done("eq_00");
    launch(8'hFF, 8'hFF); wait_done("eq_ff");    check_held("eq_ff");

    // Start while busy is ignored; start during the done cycle is accepted.
    launch(8'h01, 8'h80);
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_ignore_start", {31'b0, busy}, 1);
`endif
    wait_done("lt_01_80");
    launch(8'h80, 8'h7F); wait_done("b2b_80_7f"); check_held("b2b_80_7f");

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i == 0) ? ra : W'($urandom);
      launch(ra, rb); wait_done("rand");
    end

    // Abort mid-operation with an asynchronous reset, then a clean run.
    launch(8'h01, 8'h00);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {27'b0, busy, done, a_gt_b, a_lt_b, a_eq_b}, 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    chk("idle_after_abort", {31'b0, busy}, 0);
    launch(8'h02, 8'h02); wait_done("eq_after_abort"); check_held("eq_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
